datapath_pkt_sel_skid: RTL and testbench

Packet-locked route selector and 2-entry skid buffer that sits directly upstream of the two-way destination demux in the datapath handshake fabric. It accepts a valid/ready/last beat stream and registers it at full throughput. It samples the requested destination at the first beat of each packet, holds that destination for every beat up to and including `last`, and presents it as the demux select. The demux select therefore never changes mid-packet, and data, last and select reach the demux from flops.

---
 rtl/datapath_pkg.sv | 14 +
 rtl/datapath_pkt_sel_skid_if.sv | 39 +++
 rtl/datapath_skid_buf.sv | 62 ++++++
 rtl/datapath_pkt_sel_skid.sv | 105 ++++++++++
 tb/tb_datapath_pkt_sel_skid.sv | 319 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/datapath_pkg.sv
// Shared definitions for the datapath handshake fabric: default beat geometry
// and the packet-tracking state type.
package datapath_pkg;

  localparam int DP_DWID   = 24;
  localparam int DP_CH_NUM = 32;
  localparam int DP_CNT_W  = 16;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_PKT  = 1'b1
  } pkt_state_e;

endpackage

// File: rtl/datapath_pkt_sel_skid_if.sv
// Beat-stream bundle around the packet route selector: upstream beat channel,
// downstream demux channel with its select, and status outputs.
interface datapath_pkt_sel_skid_if
  import datapath_pkg::*;
#(
  parameter int DWID   = DP_DWID,
  parameter int CH_NUM = DP_CH_NUM,
  parameter int CNT_W  = DP_CNT_W
);

  logic                          sel_req;
  logic                          in_valid;
  logic                          in_ready;
  logic                          in_last;
  logic [CH_NUM-1:0][DWID-1:0]   in_data;
  logic                          out_valid;
  logic                          out_ready;
  logic                          out_last;
  logic [CH_NUM-1:0][DWID-1:0]   out_data;
  logic                          out_sel;
  logic                          in_pkt;
  logic [CNT_W-1:0]              pkt_cnt0;
  logic [CNT_W-1:0]              pkt_cnt1;

  // Selector side
  modport slave (
    input  sel_req, in_valid, in_last, in_data, out_ready,
    output in_ready, out_valid, out_last, out_data, out_sel,
           in_pkt, pkt_cnt0, pkt_cnt1
  );

  // Upstream source / downstream demux side
  modport master (
    output sel_req, in_valid, in_last, in_data, out_ready,
    input  in_ready, out_valid, out_last, out_data, out_sel,
           in_pkt, pkt_cnt0, pkt_cnt1
  );

endinterface

// File: rtl/datapath_skid_buf.sv
// Two-entry in-order valid/ready buffer; every output, including in_ready,
// comes straight from a flop.
module datapath_skid_buf #(
  parameter int PW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [PW-1:0] in_pld,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [PW-1:0] out_pld
);

  logic [1:0]    cnt_q, cnt_d;
  logic          rdy_q, vld_q;
  logic [PW-1:0] hd_q, hd_d;
  logic [PW-1:0] sk_q, sk_d;
  logic          acc, xfer;

  assign acc  = in_valid & rdy_q;
  assign xfer = vld_q & out_ready;

  always_comb begin
    cnt_d = cnt_q;
    if (acc & ~xfer)      cnt_d = cnt_q + 2'd1;
    else if (~acc & xfer) cnt_d = cnt_q - 2'd1;

    // Head refills from the skid slot when full, else from the input when
    // it would otherwise go empty.
    hd_d = hd_q;
    if (xfer & (cnt_q == 2'd2))                hd_d = sk_q;
    else if (acc & ((cnt_q == 2'd0) | xfer))   hd_d = in_pld;

    sk_d = sk_q;
    if (acc & (cnt_q != 2'd0) & ~xfer) sk_d = in_pld;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= 2'd0;
      rdy_q <= 1'b0;
      vld_q <= 1'b0;
      hd_q  <= '0;
    end else begin
      cnt_q <= cnt_d;
      rdy_q <= (cnt_d != 2'd2);
      vld_q <= (cnt_d != 2'd0);
      hd_q  <= hd_d;
    end
  end

  always_ff @(posedge clk) begin
    sk_q <= sk_d;
  end

  assign in_ready  = rdy_q;
  assign out_valid = vld_q;
  assign out_pld   = hd_q;

endmodule

// File: rtl/datapath_pkt_sel_skid.sv
// Packet-locked demux select plus 2-entry skid buffer. Per-destination packet
// counters are built only when DATAPATH_PKT_SEL_CNT_EN is defined.
module datapath_pkt_sel_skid
  import datapath_pkg::*;
#(
  parameter int DWID   = DP_DWID,
  parameter int CH_NUM = DP_CH_NUM,
  parameter int CNT_W  = DP_CNT_W
) (
  input  logic                   clk,
  input  logic                   rst,
  datapath_pkt_sel_skid_if.slave bus
);

  localparam int DW = CH_NUM * DWID;
  localparam int PW = DW + 2;

  pkt_state_e    state_q, state_d;
  logic          pkt_sel_q, pkt_sel_d;
  logic          acc;
  logic          beat_sel;
  logic [PW-1:0] in_pld, out_pld;

  assign acc      = bus.in_valid & bus.in_ready;
  assign beat_sel = (state_q == ST_PKT) ? pkt_sel_q : bus.sel_req;
  assign in_pld   = {beat_sel, bus.in_last, bus.in_data};

  always_comb begin
    state_d   = state_q;
    pkt_sel_d = pkt_sel_q;
    if (acc) begin
      if (state_q == ST_IDLE) begin
        if (!bus.in_last) begin
          state_d   = ST_PKT;
          pkt_sel_d = bus.sel_req;
        end
      end else if (bus.in_last) begin
        state_d = ST_IDLE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      pkt_sel_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pkt_sel_q <= pkt_sel_d;
    end
  end

  assign bus.in_pkt = (state_q == ST_PKT);

  // Buffer stage: select travels with its beat as {sel, last, data}
  datapath_skid_buf #(
    .PW (PW)
  ) u_buf (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (bus.in_valid),
    .in_ready  (bus.in_ready),
    .in_pld    (in_pld),
    .out_valid (bus.out_valid),
    .out_ready (bus.out_ready),
    .out_pld   (out_pld)
  );

  assign bus.out_sel  = out_pld[PW-1];
  assign bus.out_last = out_pld[PW-2];
  assign bus.out_data = out_pld[DW-1:0];

`ifdef DATAPATH_PKT_SEL_CNT_EN
  logic             xfer;
  logic [CNT_W-1:0] cnt0_q, cnt0_d, cnt1_q, cnt1_d;

  assign xfer = bus.out_valid & bus.out_ready;

  always_comb begin
    cnt0_d = cnt0_q;
    cnt1_d = cnt1_q;
    if (xfer & bus.out_last) begin
      if (bus.out_sel) cnt1_d = cnt1_q + 1'b1;
      else             cnt0_d = cnt0_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt0_q <= '0;
      cnt1_q <= '0;
    end else begin
      cnt0_q <= cnt0_d;
      cnt1_q <= cnt1_d;
    end
  end

  assign bus.pkt_cnt0 = cnt0_q;
  assign bus.pkt_cnt1 = cnt1_q;
`else
  assign bus.pkt_cnt0 = {CNT_W{1'b0}};
  assign bus.pkt_cnt1 = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_datapath_pkt_sel_skid.sv
// Bench for datapath_pkt_sel_skid: packet-level reference model checked every
// cycle, plus directed scenarios with literal expectations.
module tb_datapath_pkt_sel_skid;
  import datapath_pkg::*;

  localparam int DWID   = DP_DWID;
  localparam int CH_NUM = DP_CH_NUM;
  localparam int CNT_W  = 16;
  localparam int W      = DWID * CH_NUM;
`ifdef DATAPATH_PKT_SEL_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  datapath_pkt_sel_skid_if #(.DWID(DWID), .CH_NUM(CH_NUM), .CNT_W(CNT_W)) bus ();

  datapath_pkt_sel_skid #(.DWID(DWID), .CH_NUM(CH_NUM), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    bit             sel;
    bit             last;
    logic [W-1:0]   data;
  } beat_t;

  beat_t            q[$];
  int               n_tests = 0;
  int               n_fail  = 0;
  bit               started = 0;
  bit               open_m  = 0;
  bit               psel_m  = 0;
  bit               rdy_m   = 0;
  bit               last_acc = 0;
  logic [CNT_W-1:0] cnt_m [2];

  function automatic logic [W-1:0] rnd_data();
    logic [W-1:0] d;
    for (int i = 0; i < W / 32; i++) d[i*32 +: 32] = $urandom();
    return d;
  endfunction

  task automatic chk1(input string name, input logic act, input logic exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0b expected %0b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chkc(input string name, input logic [CNT_W-1:0] act, input logic [CNT_W-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chkd(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s: bound expired, got timeout expected completion at %0t", name, $time);
  endtask

  // Reference model: compares the current outputs, then advances to the
  // state expected after the coming rising edge.
  task automatic model_cycle();
    beat_t b;
    bit    xf, ac, s;
    if (started) begin
      chk1("out_valid", bus.out_valid, q.size() != 0);
      chk1("in_ready", bus.in_ready, rdy_m);
      chk1("in_pkt", bus.in_pkt, open_m);
      chkc("pkt_cnt0", bus.pkt_cnt0, CNT_EN ? cnt_m[0] : '0);
      chkc("pkt_cnt1", bus.pkt_cnt1, CNT_EN ? cnt_m[1] : '0);
      if (q.size() != 0) begin
        chkd("out_data", bus.out_data, q[0].data);
        chk1("out_last", bus.out_last, q[0].last);
        chk1("out_sel", bus.out_sel, q[0].sel);
      end
    end
    last_acc = 1'b0;
    if (rst) begin
      q.delete();
      open_m  = 1'b0;
      psel_m  = 1'b0;
      rdy_m   = 1'b0;
      cnt_m[0] = '0;
      cnt_m[1] = '0;
      started = 1'b1;
    end else if (started) begin
      xf = (q.size() != 0) && bus.out_ready;
      ac = bus.in_valid && rdy_m;
      if (xf) begin
        b = q.pop_front();
        if (b.last) cnt_m[b.sel] = cnt_m[b.sel] + 1'b1;
      end
      if (ac) begin
        if (!open_m) begin
          s = bus.sel_req;
          if (!bus.in_last) begin
            open_m = 1'b1;
            psel_m = s;
          end
        end else begin
          s = psel_m;
          if (bus.in_last) open_m = 1'b0;
        end
        q.push_back('{s, bus.in_last, bus.in_data});
        last_acc = 1'b1;
      end
      rdy_m = (q.size() < 2);
    end
  endtask

  task automatic step();
    @(negedge clk);
    model_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic s, input logic l, input logic [W-1:0] d);
    bus.in_valid = v;
    bus.sel_req  = s;
    bus.in_last  = l;
    bus.in_data  = d;
  endtask

  task automatic do_reset();
    drive(1'b0, 1'b0, 1'b0, '0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    step();
  endtask

  logic [W-1:0] dv [8];
  int           idx, guard;
  int           sent [2];

  initial begin
    drive(1'b0, 1'b0, 1'b0, '0);
    bus.out_ready = 1'b0;
    for (int i = 0; i < 8; i++) dv[i] = rnd_data();

    // Reset then idle
    step();
    step();
    chk1("rst_out_valid", bus.out_valid, 1'b0);
    chk1("rst_in_ready", bus.in_ready, 1'b0);
    chk1("rst_in_pkt", bus.in_pkt, 1'b0);
    chk1("rst_out_last", bus.out_last, 1'b0);
    chk1("rst_out_sel", bus.out_sel, 1'b0);
    chkd("rst_out_data", bus.out_data, '0);
    chkc("rst_cnt0", bus.pkt_cnt0, 16'd0);
    chkc("rst_cnt1", bus.pkt_cnt1, 16'd0);
    rst = 1'b0;
    step();
    chk1("ready_after_rst", bus.in_ready, 1'b1);
    step();
    step();
    chk1("idle_out_valid", bus.out_valid, 1'b0);

    // 4-beat packet to destination 1, sel_req toggling after beat 0
    bus.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, (i % 2) == 0, i == 3, dv[i]);
      step();
      chk1("p4_valid", bus.out_valid, 1'b1);
      chk1("p4_sel", bus.out_sel, 1'b1);
      chkd("p4_data", bus.out_data, dv[i]);
      chk1("p4_last", bus.out_last, i == 3);
      chk1("p4_in_pkt", bus.in_pkt, i != 3);
    end
    drive(1'b0, 1'b0, 1'b0, '0);
    step();
    chk1("p4_drained", bus.out_valid, 1'b0);
    chkc("p4_cnt1", bus.pkt_cnt1, CNT_EN ? 16'd1 : 16'd0);
    chkc("p4_cnt0", bus.pkt_cnt0, 16'd0);

    // Back-to-back single-beat packets 0,1,0
    do_reset();
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, i == 1, 1'b1, dv[4+i]);
      step();
      chk1("b2b_sel", bus.out_sel, i == 1);
      chkd("b2b_data", bus.out_data, dv[4+i]);
      chk1("b2b_in_pkt", bus.in_pkt, 1'b0);
    end
    drive(1'b0, 1'b0, 1'b0, '0);
    step();
    chkc("b2b_cnt0", bus.pkt_cnt0, CNT_EN ? 16'd2 : 16'd0);
    chkc("b2b_cnt1", bus.pkt_cnt1, CNT_EN ? 16'd1 : 16'd0);

    // Downstream stall for 5 cycles, then release and drain
    do_reset();
    bus.out_ready = 1'b0;
    idx = 0;
    for (int c = 0; c < 5; c++) begin
      drive(1'b1, idx[0], 1'b1, dv[idx]);
      step();
      if (last_acc) idx++;
      chkd("stall_hold_data", bus.out_data, dv[0]);
    end
    chk1("stall_in_ready", bus.in_ready, 1'b0);
    chk1("stall_out_valid", bus.out_valid, 1'b1);
    chk1("stall_two_buffered", idx == 2, 1'b1);
    bus.out_ready = 1'b1;
    drive(1'b1, idx[0], 1'b1, dv[idx]);
    step();
    if (last_acc) idx++;
    chkd("release_next", bus.out_data, dv[1]);
    guard = 0;
    while (idx < 7 && guard < 40) begin
      drive(1'b1, idx[0], 1'b1, dv[idx]);
      step();
      if (last_acc) idx++;
      guard++;
    end
    if (idx < 7) fail_now("stall_feed");
    drive(1'b0, 1'b0, 1'b0, '0);
    guard = 0;
    while (q.size() != 0 && guard < 10) begin
      step();
      guard++;
    end
    if (q.size() != 0) fail_now("stall_drain");

    // Reset during beat 2 of a 5-beat packet (counters nonzero beforehand)
    drive(1'b1, 1'b1, 1'b0, dv[0]);
    step();
    drive(1'b1, 1'b0, 1'b0, dv[1]);
    step();
    chk1("mid_in_pkt_before", bus.in_pkt, 1'b1);
    drive(1'b1, 1'b1, 1'b0, dv[2]);
    rst = 1'b1;
    step();
    chk1("mid_out_valid", bus.out_valid, 1'b0);
    chk1("mid_in_pkt", bus.in_pkt, 1'b0);
    chkc("mid_cnt0", bus.pkt_cnt0, 16'd0);
    chkc("mid_cnt1", bus.pkt_cnt1, 16'd0);
    rst = 1'b0;
    drive(1'b0, 1'b0, 1'b0, '0);
    step();
    chk1("mid_ready_back", bus.in_ready, 1'b1);
    drive(1'b1, 1'b0, 1'b1, dv[5]);
    step();
    chk1("mid_new_valid", bus.out_valid, 1'b1);
    chk1("mid_new_sel", bus.out_sel, 1'b0);
    chkd("mid_new_data", bus.out_data, dv[5]);
    drive(1'b0, 1'b0, 1'b0, '0);
    step();
    chkc("mid_new_cnt0", bus.pkt_cnt0, CNT_EN ? 16'd1 : 16'd0);

    // Random valid/ready, 1000 packets of 1..8 beats
    do_reset();
    sent[0] = 0;
    sent[1] = 0;
    for (int p = 0; p < 1000; p++) begin
      int          len, b;
      bit          s;
      logic [W-1:0] d;
      len   = $urandom_range(1, 8);
      s     = 1'($urandom_range(0, 1));
      d     = rnd_data();
      b     = 0;
      guard = 0;
      while (b < len && guard < 200) begin
        bus.in_valid  = ($urandom_range(0, 3) != 0);
        bus.sel_req   = (b == 0) ? s : 1'($urandom_range(0, 1));
        bus.in_last   = (b == len - 1);
        bus.in_data   = d;
        bus.out_ready = ($urandom_range(0, 3) != 0);
        step();
        if (last_acc) begin
          b++;
          d = rnd_data();
        end
        guard++;
      end
      if (b < len) begin
        fail_now("rand_feed");
        break;
      end
      sent[s]++;
    end
    drive(1'b0, 1'b0, 1'b0, '0);
    bus.out_ready = 1'b1;
    guard = 0;
    while (q.size() != 0 && guard < 10) begin
      step();
      guard++;
    end
    if (q.size() != 0) fail_now("rand_drain");
    step();
    chkc("rand_total0", bus.pkt_cnt0, CNT_EN ? CNT_W'(sent[0]) : '0);
    chkc("rand_total1", bus.pkt_cnt1, CNT_EN ? CNT_W'(sent[1]) : '0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
